// File: rtl/skid_buffer_stage.sv
// Two-entry valid/ready skid stage with registered o_valid/o_ready/o_data.
// Optional saturating output-transfer counter: define SKID_BUFFER_STATS_EN.
module skid_buffer_stage #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_data
`ifdef SKID_BUFFER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] o_xfer_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_valid;
  logic               r_ready;
  logic [WIDTH-1:0]   r_main;
  logic [WIDTH-1:0]   r_skid;
  logic [WIDTH-1:0]   w_main_nxt;
  logic [WIDTH-1:0]   w_skid_nxt;
  logic               w_in;
  logic               w_out;

  assign w_in    = i_valid & r_ready;
  assign w_out   = r_valid & i_ready;
  assign o_valid = r_valid;
  assign o_ready = r_ready;
  assign o_data  = r_main;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    unique case (r_state)
      EMPTY: begin
        if (w_in) begin
          w_main_nxt  = i_data;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        unique case (1'b1)
          w_in & w_out: w_main_nxt = i_data;
          w_in & ~w_out: begin
            w_skid_nxt  = i_data;
            w_state_nxt = FULL;
          end
          ~w_in & w_out: w_state_nxt = EMPTY;
          default: ;
        endcase
      end
      FULL: begin
        if (w_out) begin
          w_main_nxt  = r_skid;
          w_state_nxt = BUSY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Flags are registered from the next state so no comb path reaches ports.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt != EMPTY);
      r_ready <= (w_state_nxt != FULL);
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

`ifdef SKID_BUFFER_STATS_EN
  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_out && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_xfer_count = r_cnt;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_skid_buffer_stage.sv
// Directed + scoreboard bench for skid_buffer_stage.
// Define SKID_BUFFER_STATS_EN to also exercise the transfer counter.
module tb_skid_buffer_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
`ifdef SKID_BUFFER_STATS_EN
  logic [3:0]  o_xfer_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  skid_buffer_stage #(.WIDTH(32), .CNT_WIDTH(4)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
`ifdef SKID_BUFFER_STATS_EN
    ,
    .o_xfer_count (o_xfer_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd0);
    chk("rst_data", o_data, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    step();
    chk("rel_ready", {31'd0, o_ready}, 32'd1);
    chk("rel_valid", {31'd0, o_valid}, 32'd0);
  endtask

  logic [31:0] q[$];
  int          n_out;
  int          cyc;
  logic        f_in;
  logic        f_out;

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    #1;
    chk("por_valid", {31'd0, o_valid}, 32'd0);
    chk("por_ready", {31'd0, o_ready}, 32'd0);
    chk("por_data", o_data, 32'd0);
`ifdef SKID_BUFFER_STATS_EN
    chk("por_cnt", {28'd0, o_xfer_count}, 32'd0);
`endif
    #11;
    i_rst = 1'b0;
    step();
    chk("first_ready", {31'd0, o_ready}, 32'd1);

    // streaming
    i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      i_valid = 1'b1;
      i_data  = k;
      step();
      chk("str_data", o_data, k);
      chk("str_valid", {31'd0, o_valid}, 32'd1);
      chk("str_ready", {31'd0, o_ready}, 32'd1);
    end
    i_valid = 1'b0;
    step();
    chk("str_empty", {31'd0, o_valid}, 32'd0);

    // back-pressure
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hA;
    step();
    chk("bp_a", o_data, 32'hA);
    chk("bp_rdy_a", {31'd0, o_ready}, 32'd1);
    i_data = 32'hB;
    step();
    chk("bp_full", {31'd0, o_ready}, 32'd0);
    chk("bp_hold_a", o_data, 32'hA);
    i_data = 32'hC;
    step();
    chk("bp_c_held", {31'd0, o_ready}, 32'd0);
    chk("bp_still_a", o_data, 32'hA);
    i_ready = 1'b1;
    step();
    chk("bp_b", o_data, 32'hB);
    chk("bp_rdy_up", {31'd0, o_ready}, 32'd1);
    step();
    chk("bp_c", o_data, 32'hC);
    chk("bp_c_vld", {31'd0, o_valid}, 32'd1);
    i_valid = 1'b0;
    step();
    chk("bp_drain", {31'd0, o_valid}, 32'd0);

    // stability under stall
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h55;
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i_data = $urandom;
      step();
      chk("stb_data", o_data, 32'h55);
      chk("stb_valid", {31'd0, o_valid}, 32'd1);
    end
    i_ready = 1'b1;
    step();
    chk("stb_drain", {31'd0, o_valid}, 32'd0);

    // mid-stream reset with two words held
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h11;
    step();
    i_data = 32'h22;
    step();
    chk("mr_full", {31'd0, o_ready}, 32'd0);
    i_valid = 1'b0;
    do_reset();

    // random scoreboard
    q.delete();
    n_out = 0;
    cyc   = 0;
    while (n_out < 10000 && cyc < 60000) begin
      chk("rnd_valid", {31'd0, o_valid}, {31'd0, q.size() != 0});
      chk("rnd_ready", {31'd0, o_ready}, {31'd0, q.size() < 2});
      i_valid = $urandom_range(0, 1);
      i_ready = $urandom_range(0, 1);
      i_data  = $urandom;
      f_in    = i_valid & o_ready;
      f_out   = o_valid & i_ready;
      if (f_out) begin
        if (q.size() == 0) begin
          chk("rnd_underflow", 32'd1, 32'd0);
        end else begin
          chk("rnd_data", o_data, q.pop_front());
        end
        n_out++;
      end
      if (f_in) q.push_back(i_data);
      step();
      cyc++;
    end
    chk("rnd_done", n_out, 32'd10000);
    i_valid = 1'b0;

`ifdef SKID_BUFFER_STATS_EN
    do_reset();
    chk("cnt_clr", {28'd0, o_xfer_count}, 32'd0);
    i_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_valid = 1'b1;
      i_data  = k;
      step();
      if (k == 5) chk("cnt_mid", {28'd0, o_xfer_count}, 32'd5);
    end
    i_valid = 1'b0;
    step();
    chk("cnt_sat", {28'd0, o_xfer_count}, 32'd15);
    step();
    chk("cnt_hold", {28'd0, o_xfer_count}, 32'd15);
    do_reset();
    chk("cnt_rst", {28'd0, o_xfer_count}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
